bram_ctrl: RTL and testbench
============================

Name: bram_ctrl

Overview:
- Two-master access controller sitting directly upstream of the BRAM word memory.
- Arbitrates an instruction-fetch port (read-only) and a data port (read/write), then drives the BRAM en/we/addr/data_in pins from registers.
- Captures BRAM read data and returns it to the requesting master with a fixed latency.
- Enforces the read-to-write turnaround the BRAM needs: its data_out floats while any we bit is set.

Parameters:
- DW, 16, data word width; equals DATA_BIT_NUM.
- AW, 32, address width in words.
- MEM_WORDS, 81920, number of valid BRAM words; addresses at or above this are errors.
- STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced (optional feature only).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- f_req_valid  in  1  fetch request.
- f_req_ready  out  1  fetch request accepted this edge.
- f_req_addr  in  AW  fetch word address.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data request accepted this edge.
- d_req_we  in  1  1=write, 0=read.
- d_req_addr  in  AW  data word address.
- d_req_wdata  in  DW  write data.
- f_rsp_valid  out  1  fetch response, one-cycle pulse.
- f_rsp_data  out  DW  fetch read data.
- f_rsp_err  out  1  fetch address out of range.
- d_rsp_valid  out  1  data response, one-cycle pulse; reads and writes.
- d_rsp_data  out  DW  read data; 0 for writes and errors.
- d_rsp_err  out  1  data address out of range.
- bram_en  out  1  to BRAM en_BRAM.
- bram_rst  out  1  to BRAM rst_BRAM; equals rst.
- bram_we  out  4  to BRAM we_BRAM; 4'b1111 write, 4'b0000 otherwise.
- bram_addr  out  AW  to BRAM addr_BRAM.
- bram_wdata  out  DW  to BRAM data_in.
- bram_rdata  in  DW  from BRAM data_out.

Behaviour:
- Reset values: all *_ready, *_rsp_valid, *_rsp_err, bram_en, bram_we, bram_addr, bram_wdata and rsp data are 0.
- Reset mid-operation: all in-flight operations are discarded. No response pulses occur after rst falls for requests accepted before reset.
- Handshake: a request is accepted at an edge where valid and ready are both high. At most one ready is high per cycle. Ready is combinational from valid, arbitration state and the turnaround state.
- Arbitration: data beats fetch. Exception: the data request is a write and turnaround blocks it; fetch is then granted that cycle if valid.
- Pipeline, request accepted at edge N:
  - Stage D (cycle N..N+1): bram_* registers hold the op.
  - BRAM samples at edge N+1; read data is on bram_rdata during cycle N+1..N+2.
  - Controller registers rsp at edge N+2; rsp_valid is high for cycle N+2..N+3.
  - Latency from accept to rsp_valid is 2 cycles. Throughput is one op per cycle.
- Turnaround: a write is not accepted at an edge if stage D currently holds a read. This prevents bram_we going nonzero while read data is being presented.
  - Read after write needs no bubble.
- Idle stage D: bram_en=0, bram_we=0. bram_addr and bram_wdata hold their last values.
- Out-of-range (addr >= MEM_WORDS):
  - Request is still accepted; stage D drives bram_en=0, bram_we=0.
  - Response arrives with the same latency: err=1, data=0. Memory is not modified.
- Response tag: a 2-bit pipe (fetch/data, read/write) travels with each op. It routes the response to the correct port; write responses carry data=0.
- Simultaneous events: f_rsp_valid and d_rsp_valid are never high in the same cycle, because only one op is accepted per edge.
- Width rules: the full AW-bit address is compared against MEM_WORDS unsigned. No truncation.

Optional Feature:
- Macro BRAM_CTRL_STARVE_EN.
- When defined: a 3-bit counter counts consecutive data grants made while f_req_valid is high.
  - When the count reaches STARVE_LIMIT, the next edge with f_req_valid high grants fetch regardless of data priority; the counter then clears.
  - The counter also clears on any fetch grant, and whenever f_req_valid is low.
- When undefined: strict data-over-fetch priority with no counter. Fetch can starve indefinitely.

Test Plan:
- Fetch read addr 5 (mem[5]=16'hBEEF), accepted at edge 10 -> f_rsp_valid at cycle 12 only, f_rsp_data=16'hBEEF, err=0.
- Data write addr 7 data 16'h1234 accepted at edge 3, data read addr 7 accepted at edge 4 -> d_rsp_valid at 5 (write, data 0) and at 6 (read, data 16'h1234).
- Data read addr 2 at edge 3, data write addr 9 valid from cycle 3 -> write ready low at edge 4, accepted at edge 5; bram_we never nonzero during cycle 4..5.
- f_req_valid and d_req_valid held high for 10 cycles -> without macro, 0 fetch grants; with BRAM_CTRL_STARVE_EN, a fetch grant after every 4 data grants.
- Data read addr 81920 -> no bram_en pulse, d_rsp_valid 2 cycles later with d_rsp_err=1, data 0.
- rst asserted for one edge between accept and response -> no rsp_valid pulse; all outputs 0 in the cycle after reset.

Source files
------------

// File: rtl/bram_ctrl.sv
// Two-master (fetch/data) arbiter and 2-cycle pipeline in front of a BRAM word memory.
// Optional fetch anti-starvation counter enabled by defining BRAM_CTRL_STARVE_EN.
module bram_ctrl #(
   parameter int unsigned DW           = 16,
   parameter int unsigned AW           = 32,
   parameter int unsigned MEM_WORDS    = 81920,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          f_req_valid,
   output logic          f_req_ready,
   input  logic [AW-1:0] f_req_addr,
   input  logic          d_req_valid,
   output logic          d_req_ready,
   input  logic          d_req_we,
   input  logic [AW-1:0] d_req_addr,
   input  logic [DW-1:0] d_req_wdata,
   output logic          f_rsp_valid,
   output logic [DW-1:0] f_rsp_data,
   output logic          f_rsp_err,
   output logic          d_rsp_valid,
   output logic [DW-1:0] d_rsp_data,
   output logic          d_rsp_err,
   output logic          bram_en,
   output logic          bram_rst,
   output logic [3:0]    bram_we,
   output logic [AW-1:0] bram_addr,
   output logic [DW-1:0] bram_wdata,
   input  logic [DW-1:0] bram_rdata
);

   localparam logic [AW:0] MEM_LIM = (AW+1)'(MEM_WORDS);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_limit_check
      $error("STARVE_LIMIT must fit the 3-bit starvation counter");
   end

   // stage D: op currently presented on the bram_* pins
   logic dq_valid, dq_fetch, dq_write, dq_err;
   // stage S: op whose read data is on bram_rdata
   logic s_valid, s_fetch, s_write, s_err;

   logic          wr_block, force_fetch;
   logic          f_acc, d_acc, acc, sel_write, sel_ok;
   logic [AW-1:0] sel_addr;

`ifdef BRAM_CTRL_STARVE_EN
   logic [2:0] starve_cnt;

   always_ff @(posedge clk) begin
      if (rst || !f_req_valid || f_acc) begin
         starve_cnt <= '0;
      end else if (d_acc && starve_cnt != 3'b111) begin
         starve_cnt <= starve_cnt + 3'd1;
      end
   end

   assign force_fetch = f_req_valid && (starve_cnt >= 3'(STARVE_LIMIT));
`else
   assign force_fetch = 1'b0;
`endif

   always_comb begin
      // a write must not drive we while a read's data is still on bram_rdata
      wr_block    = d_req_we && dq_valid && !dq_write;
      d_req_ready = !rst && d_req_valid && !wr_block && !force_fetch;
      f_req_ready = !rst && f_req_valid && !d_req_ready;
      f_acc       = f_req_valid && f_req_ready;
      d_acc       = d_req_valid && d_req_ready;
      acc         = f_acc || d_acc;
      sel_addr    = d_acc ? d_req_addr : f_req_addr;
      sel_write   = d_acc && d_req_we;
      sel_ok      = {1'b0, sel_addr} < MEM_LIM;
   end

   assign bram_rst = rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         dq_valid    <= 1'b0;
         dq_fetch    <= 1'b0;
         dq_write    <= 1'b0;
         dq_err      <= 1'b0;
         s_valid     <= 1'b0;
         s_fetch     <= 1'b0;
         s_write     <= 1'b0;
         s_err       <= 1'b0;
         bram_en     <= 1'b0;
         bram_we     <= '0;
         bram_addr   <= '0;
         bram_wdata  <= '0;
         f_rsp_valid <= 1'b0;
         f_rsp_data  <= '0;
         f_rsp_err   <= 1'b0;
         d_rsp_valid <= 1'b0;
         d_rsp_data  <= '0;
         d_rsp_err   <= 1'b0;
      end else begin
         dq_valid <= acc;
         dq_fetch <= f_acc;
         dq_write <= sel_write;
         dq_err   <= acc && !sel_ok;
         bram_en  <= acc && sel_ok;
         bram_we  <= {4{acc && sel_ok && sel_write}};
         if (acc) begin
            bram_addr <= sel_addr;
         end
         if (sel_write) begin
            bram_wdata <= d_req_wdata;
         end

         s_valid <= dq_valid;
         s_fetch <= dq_fetch;
         s_write <= dq_write;
         s_err   <= dq_err;

         f_rsp_valid <= s_valid && s_fetch;
         f_rsp_err   <= s_valid && s_fetch && s_err;
         f_rsp_data  <= (s_valid && s_fetch && !s_err) ? bram_rdata : '0;
         d_rsp_valid <= s_valid && !s_fetch;
         d_rsp_err   <= s_valid && !s_fetch && s_err;
         d_rsp_data  <= (s_valid && !s_fetch && !s_write && !s_err) ? bram_rdata : '0;
      end
   end

endmodule

// File: tb/tb_bram_ctrl.sv
// Directed bench for bram_ctrl with a behavioural BRAM model; checks the
// BRAM_CTRL_STARVE_EN behaviour when that macro is defined.
module tb_bram_ctrl;

   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 32;
   localparam int unsigned WORDS = 81920;

   logic          clk = 1'b0;
   logic          rst;
   logic          f_req_valid, f_req_ready;
   logic [AW-1:0] f_req_addr;
   logic          d_req_valid, d_req_ready, d_req_we;
   logic [AW-1:0] d_req_addr;
   logic [DW-1:0] d_req_wdata;
   logic          f_rsp_valid, f_rsp_err, d_rsp_valid, d_rsp_err;
   logic [DW-1:0] f_rsp_data, d_rsp_data;
   logic          bram_en, bram_rst;
   logic [3:0]    bram_we;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_wdata, bram_rdata;

   int tests  = 0;
   int failed = 0;

   bram_ctrl #(.DW(DW), .AW(AW), .MEM_WORDS(WORDS), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
      .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
      .bram_en(bram_en), .bram_rst(bram_rst), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
   );

   always #5 clk = ~clk;

   // BRAM model: data_out is garbage (16'hDEAD) after a write edge
   logic [DW-1:0] mem [0:WORDS-1];
   logic [DW-1:0] rdata_q = '0;
   assign bram_rdata = rdata_q;

   initial begin
      for (int i = 0; i < int'(WORDS); i++) mem[i] = '0;
   end

   always @(posedge clk) begin
      if (bram_en && bram_addr < WORDS) begin
         if (bram_we == 4'hF) begin
            mem[bram_addr] <= bram_wdata;
            rdata_q        <= 16'hDEAD;
         end else begin
            rdata_q <= mem[bram_addr];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        fetch;
      logic        we;
      logic [31:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[12];

   task automatic apply_op(input vec_t v);
      @(negedge clk);
      f_req_valid = v.fetch;
      f_req_addr  = v.addr;
      d_req_valid = !v.fetch;
      d_req_we    = v.we;
      d_req_addr  = v.addr;
      d_req_wdata = v.wdata;
      #1;
      check("f_ready", f_req_ready, v.fetch);
      check("d_ready", d_req_ready, !v.fetch);
      @(posedge clk);
      @(negedge clk);
      f_req_valid = 1'b0;
      d_req_valid = 1'b0;
      check("bram_en", bram_en, !v.exp_err);
      check("bram_we", bram_we, (v.we && !v.exp_err) ? 4'hF : 4'h0);
      check("bram_addr", bram_addr, v.addr);
      if (v.we) check("bram_wdata", bram_wdata, v.wdata);
      @(negedge clk);
      check("early_rsp", {f_rsp_valid, d_rsp_valid}, 2'b00);
      @(negedge clk);
      check("f_rsp_valid", f_rsp_valid, v.fetch);
      check("d_rsp_valid", d_rsp_valid, !v.fetch);
      check("rsp_data", v.fetch ? f_rsp_data : d_rsp_data, v.exp_data);
      check("rsp_err", v.fetch ? f_rsp_err : d_rsp_err, v.exp_err);
      @(negedge clk);
      check("rsp_pulse_end", {f_rsp_valid, d_rsp_valid}, 2'b00);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_f_ready"}, f_req_ready, 1'b0);
      check({tag, "_d_ready"}, d_req_ready, 1'b0);
      check({tag, "_rsp_valid"}, {f_rsp_valid, d_rsp_valid}, 2'b00);
      check({tag, "_rsp_err"}, {f_rsp_err, d_rsp_err}, 2'b00);
      check({tag, "_rsp_data"}, {f_rsp_data, d_rsp_data}, 32'h0);
      check({tag, "_bram_en_we"}, {bram_en, bram_we}, 5'h0);
      check({tag, "_bram_addr"}, bram_addr, 32'h0);
      check({tag, "_bram_wdata"}, bram_wdata, 16'h0);
   endtask

   int fgrants, dgrants, pulses;

   initial begin
      //          fetch we  addr           wdata     exp_data  err
      vecs[0]  = '{1'b0, 1'b1, 32'd5,        16'hBEEF, 16'h0000, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 32'd2,        16'h2222, 16'h0000, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'd5,        16'h0000, 16'hBEEF, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 32'd5,        16'h0000, 16'hBEEF, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 32'd81920,    16'h1111, 16'h0000, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 32'd81920,    16'h0000, 16'h0000, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 32'd81920,    16'h0000, 16'h0000, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 16'h0000, 16'h0000, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 32'd81919,    16'hA5A5, 16'h0000, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'd81919,    16'h0000, 16'hA5A5, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 32'h80000005, 16'h0000, 16'h0000, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 32'd2,        16'h0000, 16'h2222, 1'b0};

      rst = 1'b1;
      f_req_valid = 1'b0; f_req_addr = '0;
      d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_bram_rst", bram_rst, 1'b1);
      check_all_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 12; i++) apply_op(vecs[i]);

      // write 7 then read 7 on the next edge: no bubble, read sees new data
      @(negedge clk);
      d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'd7; d_req_wdata = 16'h1234;
      #1 check("raw_wr_ready", d_req_ready, 1'b1);
      @(negedge clk);
      d_req_we = 1'b0;
      #1 check("raw_rd_ready", d_req_ready, 1'b1);
      @(negedge clk);
      d_req_valid = 1'b0;
      check("raw_no_rsp_yet", d_rsp_valid, 1'b0);
      @(negedge clk);
      check("raw_wr_rsp", {d_rsp_valid, d_rsp_err, d_rsp_data}, {2'b10, 16'h0000});
      @(negedge clk);
      check("raw_rd_rsp", {d_rsp_valid, d_rsp_err, d_rsp_data}, {2'b10, 16'h1234});
      @(negedge clk);

      // read 2 followed by a write 9: one bubble, we stays 0 while read data is out
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'd2;
      #1 check("ta_rd_ready", d_req_ready, 1'b1);
      @(negedge clk);
      d_req_we = 1'b1; d_req_addr = 32'd9; d_req_wdata = 16'h5555;
      #1 check("ta_wr_blocked", d_req_ready, 1'b0);
      check("ta_we_zero_1", bram_we, 4'h0);
      check("ta_rd_en", bram_en, 1'b1);
      @(negedge clk);
      check("ta_wr_ready", d_req_ready, 1'b1);
      check("ta_we_zero_2", bram_we, 4'h0);
      @(negedge clk);
      d_req_valid = 1'b0;
      check("ta_we_set", bram_we, 4'hF);
      check("ta_rd_rsp", {d_rsp_valid, d_rsp_data}, {1'b1, 16'h2222});
      @(negedge clk);
      check("ta_gap", d_rsp_valid, 1'b0);
      @(negedge clk);
      check("ta_wr_rsp", {d_rsp_valid, d_rsp_data}, {1'b1, 16'h0000});
      check("ta_mem9", mem[9], 16'h5555);
      @(negedge clk);

      // both masters continuously valid for 10 edges
      fgrants = 0; dgrants = 0;
      f_req_valid = 1'b1; f_req_addr = 32'd1;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'd3;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("onehot_ready", f_req_ready && d_req_ready, 1'b0);
         if (f_req_ready) fgrants++;
         if (d_req_ready) dgrants++;
         @(negedge clk);
      end
      f_req_valid = 1'b0; d_req_valid = 1'b0;
`ifdef BRAM_CTRL_STARVE_EN
      check("starve_fetch_grants", fgrants, 2);
      check("starve_data_grants", dgrants, 8);
`else
      check("starve_fetch_grants", fgrants, 0);
      check("starve_data_grants", dgrants, 10);
`endif
      repeat (4) @(negedge clk);

      // reset between accept and response discards the op
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'd5;
      @(negedge clk);
      d_req_valid = 1'b0;
      rst = 1'b1;
      #1 check("mid_bram_rst", bram_rst, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("post_rst");
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (f_rsp_valid || d_rsp_valid) pulses++;
      end
      check("post_rst_pulses", pulses, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
